riscv_io_bridge_mmio: RTL and testbench

Parametrised memory-mapped I/O bridge between the data-memory port of the RISC-V core and the board peripherals. It decodes a 256-byte I/O window and serves accesses in that window from local registers: debounced switches, LEDs, a free-running cycle counter and a compare timer with a sticky match flag. Sub-word stores are merged into the correct byte lanes. All other addresses pass through to the data cache, whose write enable is gated here.

---
 rtl/riscv_io_bridge_mmio.sv | 159 +++++++++++++++
 tb/tb_riscv_io_bridge_mmio.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_io_bridge_mmio.sv
// MMIO bridge between the core data port and board peripherals: a 256-byte I/O window
// holding switches, LEDs, a cycle counter and a compare timer. All other addresses pass to the data cache.

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'd0
`define CACHE_D_WRITE_SH 2'd1
`define CACHE_D_WRITE_SW 2'd2
`endif

module riscv_io_bridge_mmio #(
  parameter logic [31:0] IO_BASE         = 32'hfffffc00,
  parameter int unsigned SW_WIDTH        = 24,
  parameter int unsigned LED_WIDTH       = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cache_d_write_en,
  input  logic [`CACHE_D_WRITE_LEN-1:0] cache_d_write,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   data_to_cache,
  input  logic [31:0]                   data_out_cache,
  input  logic [SW_WIDTH-1:0]           sw,
  output logic [31:0]                   data_out,
  output logic                          cache_d_write_en_o,
  output logic [LED_WIDTH-1:0]          led,
  output logic                          timer_irq
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  localparam logic [5:0] IDX_SW    = 6'd0;
  localparam logic [5:0] IDX_LED   = 6'd1;
  localparam logic [5:0] IDX_CYCLE = 6'd2;
  localparam logic [5:0] IDX_CMP   = 6'd3;
  localparam logic [5:0] IDX_STAT  = 6'd4;

  logic                is_io;
  logic [5:0]          idx;
  logic [31:0]         cycle;
  logic [31:0]         cmp;
  logic                en;
  logic [SW_WIDTH-1:0] sw_reg;
  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [SW_WIDTH-1:0] cand;
  logic [CNT_W-1:0]    deb_cnt;

  logic [31:0] rd_word;
  logic [31:0] merged;
  logic        wr_ok;
  logic        low_byte_wr;
  logic        wr;
  logic        stat_clr;
  logic        match_set;

  assign is_io = (addr & 32'hffffff00) == IO_BASE;
  assign idx   = addr[7:2];

  assign data_out           = is_io ? rd_word : data_out_cache;
  assign cache_d_write_en_o = cache_d_write_en & ~is_io;

  // Register read mux; also the base value for store merging
  always_comb begin
    rd_word = '0;
    case (idx)
      IDX_SW:    rd_word = 32'(sw_reg);
      IDX_LED:   rd_word = 32'(led);
      IDX_CYCLE: rd_word = cycle;
      IDX_CMP:   rd_word = cmp;
      IDX_STAT:  rd_word = {30'd0, en, timer_irq};
      default:   rd_word = '0;
    endcase
  end

  // Byte-lane merge of store data into the current register value
  always_comb begin
    merged      = rd_word;
    wr_ok       = 1'b1;
    low_byte_wr = 1'b0;
    case (cache_d_write)
      `CACHE_D_WRITE_SW: begin
        merged      = data_to_cache;
        low_byte_wr = 1'b1;
      end
      `CACHE_D_WRITE_SH: begin
        if (addr[1]) begin
          merged[31:16] = data_to_cache[15:0];
        end else begin
          merged[15:0] = data_to_cache[15:0];
          low_byte_wr  = 1'b1;
        end
      end
      `CACHE_D_WRITE_SB: begin
        case (addr[1:0])
          2'd0: begin
            merged[7:0] = data_to_cache[7:0];
            low_byte_wr = 1'b1;
          end
          2'd1:    merged[15:8]  = data_to_cache[7:0];
          2'd2:    merged[23:16] = data_to_cache[7:0];
          default: merged[31:24] = data_to_cache[7:0];
        endcase
      end
      default: wr_ok = 1'b0;
    endcase
  end

  assign wr        = cache_d_write_en & is_io & wr_ok;
  // W1C only counts when byte 0 of STAT is actually part of the store
  assign stat_clr  = wr & (idx == IDX_STAT) & low_byte_wr & merged[0];
  assign match_set = en & (cycle == cmp);

  // Register file, cycle counter and timer flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle     <= '0;
      led       <= '0;
      cmp       <= '0;
      en        <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;
      if (wr && idx == IDX_LED) led <= merged[LED_WIDTH-1:0];
      if (wr && idx == IDX_CMP) cmp <= merged;
      if (wr && idx == IDX_STAT) en <= merged[1];
      if (match_set) begin
        timer_irq <= 1'b1;
      end else if (stat_clr) begin
        timer_irq <= 1'b0;
      end
    end
  end

  // Switch synchroniser and debounce; SW loads on the edge that completes the stable window
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      deb_cnt <= '0;
      sw_reg  <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= '0;
      end else begin
        if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + CNT_W'(1);
        if (deb_cnt == DEB_LOAD || deb_cnt == DEB_MAX) sw_reg <= cand;
      end
    end
  end

endmodule

// File: tb/tb_riscv_io_bridge_mmio.sv
// Self-checking bench for riscv_io_bridge_mmio: vector table with a scoreboard queue,
// plus hand sequences for cycle counter, timer match/W1C and switch debounce.

`ifndef CACHE_D_WRITE_LEN
`define CACHE_D_WRITE_LEN 2
`define CACHE_D_WRITE_SB 2'd0
`define CACHE_D_WRITE_SH 2'd1
`define CACHE_D_WRITE_SW 2'd2
`endif

module tb_riscv_io_bridge_mmio;

  localparam logic [31:0] IO = 32'hfffffc00;
  localparam logic [1:0]  SB = `CACHE_D_WRITE_SB;
  localparam logic [1:0]  SH = `CACHE_D_WRITE_SH;
  localparam logic [1:0]  SW = `CACHE_D_WRITE_SW;
  localparam logic [1:0]  BAD = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] crd;
  logic [23:0] sw;
  logic [31:0] data_out;
  logic        we_o;
  logic [23:0] led;
  logic        timer_irq;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] tb_cycle;
  logic [31:0] t_cmp;

  riscv_io_bridge_mmio #(
    .IO_BASE(32'hfffffc00), .SW_WIDTH(24), .LED_WIDTH(24), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .cache_d_write_en(we), .cache_d_write(size), .addr(addr),
    .data_to_cache(wdata), .data_out_cache(crd), .sw(sw), .data_out(data_out),
    .cache_d_write_en_o(we_o), .led(led), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  // Reference cycle counter
  always @(posedge clk) begin
    if (rst) tb_cycle <= '0;
    else     tb_cycle <= tb_cycle + 32'd1;
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] crd;
    logic [31:0] exp_do;
    logic        exp_weo;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs[18];
  vec_t sb_q[$];

  function automatic vec_t mk(string n, logic w, logic [1:0] s, logic [31:0] a, logic [31:0] d,
                              logic [31:0] c, logic [31:0] edo, logic ewo, logic [23:0] el);
    vec_t v;
    v.name = n; v.we = w; v.size = s; v.addr = a; v.wdata = d; v.crd = c;
    v.exp_do = edo; v.exp_weo = ewo; v.exp_led = el;
    return v;
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic drive(logic w, logic [1:0] s, logic [31:0] a, logic [31:0] d);
    we = w; size = s; addr = a; wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = mk("rd_led_rst",   0, SW, IO+32'h04, 32'h0,        32'h0,        32'h0,        0, 24'h0);
    vecs[1]  = mk("rd_cmp_rst",   0, SW, IO+32'h0c, 32'h0,        32'h0,        32'h0,        0, 24'h0);
    vecs[2]  = mk("rd_stat_rst",  0, SW, IO+32'h10, 32'h0,        32'h0,        32'h0,        0, 24'h0);
    vecs[3]  = mk("st_sw_reg",    1, SW, IO+32'h00, 32'hffffffff, 32'h0,        32'h0,        0, 24'h0);
    vecs[4]  = mk("rd_sw_reg",    0, SW, IO+32'h00, 32'h0,        32'h0,        32'h0,        0, 24'h0);
    vecs[5]  = mk("st_led_word",  1, SW, IO+32'h04, 32'h12345678, 32'h0,        32'h0,        0, 24'h0);
    vecs[6]  = mk("st_led_byte",  1, SB, IO+32'h05, 32'h000000ab, 32'h0,        32'h00345678, 0, 24'h345678);
    vecs[7]  = mk("st_led_half",  1, SH, IO+32'h06, 32'h0000cdef, 32'h0,        32'h0034ab78, 0, 24'h34ab78);
    vecs[8]  = mk("rd_led_merge", 0, SW, IO+32'h04, 32'h0,        32'h0,        32'h00efab78, 0, 24'hefab78);
    vecs[9]  = mk("st_mem",       1, SW, 32'h1000,  32'hdeadbeef, 32'h11112222, 32'h11112222, 1, 24'hefab78);
    vecs[10] = mk("rd_mem",       0, SW, 32'h1000,  32'h0,        32'h33334444, 32'h33334444, 0, 24'hefab78);
    vecs[11] = mk("rd_led_after", 0, SW, IO+32'h04, 32'h0,        32'h0,        32'h00efab78, 0, 24'hefab78);
    vecs[12] = mk("st_bad_size",  1, BAD, IO+32'h04, 32'h0,       32'h0,        32'h00efab78, 0, 24'hefab78);
    vecs[13] = mk("rd_bad_size",  0, SW, IO+32'h04, 32'h0,        32'h0,        32'h00efab78, 0, 24'hefab78);
    vecs[14] = mk("st_led_b3",    1, SB, IO+32'h07, 32'h00000055, 32'h0,        32'h00efab78, 0, 24'hefab78);
    vecs[15] = mk("rd_led_b3",    0, SW, IO+32'h04, 32'h0,        32'h0,        32'h00efab78, 0, 24'hefab78);
    vecs[16] = mk("st_below_win", 1, SW, 32'hfffffb04, 32'h0,     32'h0000abcd, 32'h0000abcd, 1, 24'hefab78);
    vecs[17] = mk("rd_led_below", 0, SW, IO+32'h04, 32'h0,        32'h0,        32'h00efab78, 0, 24'hefab78);

    rst = 1'b1; sw = '0; crd = '0;
    drive(0, SW, IO + 32'h08, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and first cycle-counter reads
    @(negedge clk);
    check("rst_irq", 32'(timer_irq), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("cycle_first", data_out, 32'h0);
    for (int k = 1; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      check("cycle_count", data_out, 32'(k));
    end

    // Vector table through scoreboard
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      drive(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      crd = vecs[i].crd;
      sb_q.push_back(vecs[i]);
      @(negedge clk);
      v = sb_q.pop_front();
      check({v.name, "_data"}, data_out, v.exp_do);
      check({v.name, "_weo"}, 32'(we_o), 32'(v.exp_weo));
      check({v.name, "_led"}, 32'(led), 32'(v.exp_led));
    end
    next_cycle();
    drive(0, SW, IO + 32'h08, 32'h0);
    crd = '0;
    @(negedge clk);
    check("cycle_model", data_out, tb_cycle);

    // Timer: match rises one edge after CYCLE == CMP
    next_cycle();
    t_cmp = tb_cycle + 32'd6;
    drive(1, SW, IO + 32'h0c, t_cmp);
    next_cycle();
    drive(1, SW, IO + 32'h10, 32'h2);
    next_cycle();
    drive(0, SW, IO + 32'h10, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("irq_match", 32'(timer_irq), 32'(tb_cycle >= t_cmp + 32'd1));
      next_cycle();
    end

    // W1C with no concurrent match clears
    drive(1, SW, IO + 32'h10, 32'h3);
    next_cycle();
    drive(0, SW, IO + 32'h10, 32'h0);
    @(negedge clk);
    check("w1c_clear_irq", 32'(timer_irq), 32'h0);
    check("w1c_clear_stat", data_out, 32'h2);

    // W1C in the same cycle as a new match: set wins
    next_cycle();
    drive(1, SW, IO + 32'h0c, tb_cycle + 32'd2);
    next_cycle();
    drive(0, SW, IO + 32'h10, 32'h0);
    next_cycle();
    drive(1, SW, IO + 32'h10, 32'h3);
    next_cycle();
    drive(0, SW, IO + 32'h10, 32'h0);
    @(negedge clk);
    check("set_wins_irq", 32'(timer_irq), 32'h1);
    check("set_wins_stat", data_out, 32'h3);

    // CMP byte merge; writing CMP leaves MATCH alone
    next_cycle();
    drive(1, SW, IO + 32'h0c, 32'h11223344);
    next_cycle();
    drive(1, SB, IO + 32'h0e, 32'h00000099);
    next_cycle();
    drive(0, SW, IO + 32'h0c, 32'h0);
    @(negedge clk);
    check("cmp_merge", data_out, 32'h11993344);
    check("cmp_keeps_irq", 32'(timer_irq), 32'h1);

    // EN=0: no match even when CYCLE passes CMP
    next_cycle();
    drive(1, SW, IO + 32'h10, 32'h1);
    next_cycle();
    drive(1, SW, IO + 32'h0c, tb_cycle + 32'd2);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      drive(0, SW, IO + 32'h10, 32'h0);
      @(negedge clk);
      check("irq_disabled", 32'(timer_irq), 32'h0);
    end

    // Debounce: steady change appears after exactly 6 cycles
    next_cycle();
    sw = 24'h5;
    drive(0, SW, IO + 32'h00, 32'h0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("deb_latency", data_out, (k >= 6) ? 32'h5 : 32'h0);
      next_cycle();
    end
    sw = 24'h0;
    repeat (10) next_cycle();
    @(negedge clk);
    check("deb_return", data_out, 32'h0);

    // 3-cycle glitch is rejected
    next_cycle();
    sw = 24'h3;
    repeat (3) next_cycle();
    sw = 24'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("deb_glitch", data_out, 32'h0);
      next_cycle();
    end

    // Pulse of exactly DEBOUNCE_CYCLES is accepted
    sw = 24'h3;
    repeat (4) next_cycle();
    sw = 24'h0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("deb_min_pulse", data_out, 32'h3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
